// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one multi-cycle fpUnit among NUM_REQ requesters.
// One operation in flight at a time; each operation is followed by a one-cycle RELEASE gap.
module fp_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_dataa,
    input  logic [32*NUM_REQ-1:0]  req_datab,
    input  logic [3*NUM_REQ-1:0]   req_op,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            result,
    output logic                   err,
    output logic [31:0]            fp_dataa,
    output logic [31:0]            fp_datab,
    output logic [2:0]             fp_operation,
    output logic                   fp_clk_en,
    input  logic                   fp_done,
    input  logic [31:0]            fp_result,
    output logic [1:0]             dbg_state
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PW-1:0]       r_ptr;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [31:0]         r_dataa;
    logic [31:0]         r_datab;
    logic [2:0]          r_op;

    logic                w_found;
    logic [PW-1:0]       w_win;
    logic [PW:0]         w_sum;
    logic [NUM_REQ-1:0]  w_onehot;
    logic [31:0]         w_sel_a;
    logic [31:0]         w_sel_b;
    logic [2:0]          w_sel_op;
    logic                w_timeout;

    // Search starts at r_ptr and wraps past NUM_REQ-1 back to 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= (PW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (PW+1)'(NUM_REQ);
            end
            if (!w_found && req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        w_sel_a  = '0;
        w_sel_b  = '0;
        w_sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_onehot[i] = 1'b1;
                w_sel_a     = req_dataa[32*i +: 32];
                w_sel_b     = req_datab[32*i +: 32];
                w_sel_op    = req_op[3*i +: 3];
            end
        end
    end

    // r_cnt holds (ISSUE cycle number - 1), so the timeout fires on ISSUE cycle TIMEOUT.
    assign w_timeout = (r_state == S_ISSUE) && (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_found) w_next = S_ISSUE;
            S_ISSUE:   if (fp_done || w_timeout) w_next = S_RELEASE;
            S_RELEASE: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Completion is combinational so the fpUnit result reaches the requester with no added latency.
    always_comb begin
        done   = '0;
        err    = 1'b0;
        result = '0;
        if (r_state == S_ISSUE) begin
            if (fp_done) begin
                done   = r_gnt;
                result = fp_result;
            end else if (w_timeout) begin
                done = r_gnt;
                err  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_dataa <= '0;
            r_datab <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_found) begin
                        r_gnt   <= w_onehot;
                        r_dataa <= w_sel_a;
                        r_datab <= w_sel_b;
                        r_op    <= w_sel_op;
                        r_ptr   <= (w_win == PW'(NUM_REQ - 1)) ? '0 : w_win + PW'(1);
                    end
                end
                S_ISSUE: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (fp_done || w_timeout) begin
                        r_gnt <= '0;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign gnt          = r_gnt;
    assign fp_dataa     = r_dataa;
    assign fp_datab     = r_datab;
    assign fp_operation = r_op;
    assign fp_clk_en    = (r_state == S_ISSUE);
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: requester model, behavioural fpUnit, round-robin reference model
// and a done-driven scoreboard.
module tb_fp_unit_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;
    localparam int EW = 102;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req = '0;
    logic [32*N-1:0] req_dataa = '0;
    logic [32*N-1:0] req_datab = '0;
    logic [3*N-1:0]  req_op = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    done;
    logic [31:0]     result;
    logic            err;
    logic [31:0]     fp_dataa;
    logic [31:0]     fp_datab;
    logic [2:0]      fp_operation;
    logic            fp_clk_en;
    logic            fp_done = 1'b0;
    logic [31:0]     fp_result = '0;
    logic [1:0]      dbg_state;

    fp_unit_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_dataa(req_dataa), .req_datab(req_datab),
        .req_op(req_op), .gnt(gnt), .done(done), .result(result), .err(err),
        .fp_dataa(fp_dataa), .fp_datab(fp_datab), .fp_operation(fp_operation),
        .fp_clk_en(fp_clk_en), .fp_done(fp_done), .fp_result(fp_result), .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- counters and check helper ----------------
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- requester model ----------------
    bit          m_req[N];
    logic [31:0] m_a[N];
    logic [31:0] m_b[N];
    logic [2:0]  m_op[N];
    int          m_ptr = 0;

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            req[i]              = m_req[i];
            req_dataa[32*i +: 32] = m_a[i];
            req_datab[32*i +: 32] = m_b[i];
            req_op[3*i +: 3]      = m_op[i];
        end
    endtask

    task automatic new_operands(input int j);
        m_a[j]  = $urandom;
        m_b[j]  = $urandom;
        m_op[j] = 3'($urandom_range(0, 5));
    endtask

    // First active requester at or after m_ptr, wrapping around.
    function automatic int pick();
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (m_req[idx]) return idx;
        end
        return -1;
    endfunction

    // ---------------- behavioural fpUnit ----------------
    int          lat_cur = 1;
    logic [31:0] res_cur = '0;
    int          fu_cnt = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (fp_clk_en) begin
                fu_cnt++;
                if (fu_cnt == lat_cur) begin
                    fp_done   = 1'b1;
                    fp_result = res_cur;
                end else begin
                    fp_done   = 1'b0;
                    fp_result = $urandom;
                end
            end else begin
                // Stray fp_done outside an operation must be ignored by the arbiter.
                fu_cnt    = 0;
                fp_done   = ($urandom_range(0, 3) == 0);
                fp_result = $urandom;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [EW-1:0] exp_q[$];
    int            done_cnt = 0;
    int            last_done = -1000;
    logic [N-1:0]  prev_gnt = '0;

    initial begin
        logic [EW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_gnt  = '0;
                last_done = -1000;
            end else begin
                check("gnt_vs_clk_en", 64'(gnt != '0), 64'(fp_clk_en));
                if (gnt != '0 && prev_gnt == '0) begin
                    check("grant_gap_ge3", 64'((cyc - last_done) >= 3), 64'(1));
                end
                if (done != '0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_done", 64'(done), 64'(0));
                    end else begin
                        e = exp_q.pop_front();
                        check("done_vec", 64'(done), 64'(1) << e[101:100]);
                        check("err", 64'(err), 64'(e[99]));
                        check("result", 64'(result), 64'(e[98:67]));
                        check("fp_operation", 64'(fp_operation), 64'(e[66:64]));
                        check("fp_dataa", 64'(fp_dataa), 64'(e[63:32]));
                        check("fp_datab", 64'(fp_datab), 64'(e[31:0]));
                    end
                    last_done = cyc;
                    done_cnt++;
                end else begin
                    check("err_without_done", 64'(err), 64'(0));
                end
                prev_gnt = gnt;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at negedge+1 of an IDLE cycle; returns at negedge+1 of the next IDLE cycle.
    // rel_mode 0: winner drops req right after done; 1: keeps req through RELEASE; 2: holds req.
    task automatic run_txn(input int lat, input int rel_mode, input bit churn);
        int          w;
        int          k;
        int          start;
        int          exp_k;
        logic        exp_err;
        logic [31:0] exp_res;
        if (pick() < 0) begin
            k = $urandom_range(0, N-1);
            m_req[k] = 1'b1;
            new_operands(k);
        end
        apply();
        w       = pick();
        m_ptr   = (w + 1) % N;
        lat_cur = lat;
        res_cur = $urandom;
        exp_err = (lat > TO);
        exp_k   = (lat < TO) ? lat : TO;
        exp_res = exp_err ? 32'd0 : res_cur;
        exp_q.push_back({2'(w), exp_err, exp_res, m_op[w], m_a[w], m_b[w]});
        start = done_cnt;
        @(negedge clk); #1;
        check("grant_onehot", 64'(gnt), 64'(1) << w);
        check("issue_clk_en", 64'(fp_clk_en), 64'(1));
        check("issue_operation", 64'(fp_operation), 64'(m_op[w]));
        check("issue_dataa", 64'(fp_dataa), 64'(m_a[w]));
        k = 1;
        while (done_cnt == start && k < TO + 20) begin
            if (churn) begin
                for (int j = 0; j < N; j++) begin
                    if (j != w && $urandom_range(0, 5) == 0) begin
                        m_req[j] = $urandom_range(0, 1);
                        new_operands(j);
                    end
                end
                if ($urandom_range(0, 9) == 0) m_req[w] = 1'b0;
                apply();
            end
            @(negedge clk); #1;
            k++;
        end
        check("done_cycle", 64'(k), 64'(exp_k));
        if (done_cnt == start) exp_q.delete();
        if (rel_mode == 0) begin
            m_req[w] = 1'b0;
            apply();
        end
        @(negedge clk); #1;
        @(negedge clk); #1;
        if (rel_mode == 1) begin
            m_req[w] = 1'b0;
            apply();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            check("idle_no_grant", 64'(gnt), 64'(0));
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_ctl"}, 64'({gnt, done, err, fp_clk_en, fp_operation, dbg_state}), 64'(0));
        check({name, "_dataa"}, 64'(fp_dataa), 64'(0));
        check({name, "_datab"}, 64'(fp_datab), 64'(0));
        check({name, "_result"}, 64'(result), 64'(0));
    endtask

    // Asserts reset at negedge+1, checks outputs clear without a clock edge, releases at negedge+1.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        check_all_zero("reset_async");
        exp_q.delete();
        m_ptr = 0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b0;
            m_a[i]   = '0;
            m_b[i]   = '0;
            m_op[i]  = '0;
        end
        apply();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset_state");
        rst = 1'b1;

        // single request, fdiv-free "float" op with fp_done on ISSUE cycle 4
        m_req[0] = 1'b1;
        m_a[0]   = 32'd7;
        m_b[0]   = $urandom;
        m_op[0]  = 3'd5;
        run_txn(4, 0, 1'b0);

        // all requesters held: order 0,1,2,3,0 from reset
        @(negedge clk);
        #1;
        do_reset();
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b1;
            new_operands(i);
        end
        repeat (5) run_txn($urandom_range(1, 5), 2, 1'b0);

        // lone requester 2, req kept through RELEASE then dropped: no re-grant
        for (int i = 0; i < N; i++) m_req[i] = 1'b0;
        apply();
        idle_cycles(2);
        repeat (4) begin
            m_req[2] = 1'b1;
            new_operands(2);
            run_txn($urandom_range(1, 4), 1, 1'b0);
            idle_cycles(2);
        end

        // timeout with no fp_done, then fp_done coinciding with timeout
        m_req[1] = 1'b1;
        new_operands(1);
        run_txn(TO + 10, 0, 1'b0);
        m_req[1] = 1'b1;
        new_operands(1);
        run_txn(TO, 0, 1'b0);

        // reset mid-ISSUE, then req=1000 and req=0110 with pointer back at 0
        for (int i = 0; i < N; i++) begin
            m_req[i] = 1'b1;
            new_operands(i);
        end
        apply();
        lat_cur = 1000;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("pre_reset_issue", 64'(fp_clk_en), 64'(1));
        for (int i = 0; i < N; i++) m_req[i] = 1'b0;
        m_req[3] = 1'b1;
        do_reset();
        run_txn(3, 0, 1'b0);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) m_req[i] = 1'b0;
        m_req[1] = 1'b1;
        m_req[2] = 1'b1;
        do_reset();
        run_txn(2, 0, 1'b0);

        // randomized traffic with mid-ISSUE churn on other requesters
        repeat (40) begin
            for (int j = 0; j < N; j++) begin
                if (!m_req[j] && $urandom_range(0, 1) == 1) begin
                    m_req[j] = 1'b1;
                    new_operands(j);
                end
            end
            run_txn(($urandom_range(0, 9) == 0) ? TO : $urandom_range(1, 8),
                    $urandom_range(0, 2), 1'b1);
        end

        for (int i = 0; i < N; i++) m_req[i] = 1'b0;
        apply();
        idle_cycles(3);
        check("scoreboard_drain", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
